// File: rtl/parity_pkg.sv
// parity_pkg: shared receiver state encoding and serial line levels
package parity_pkg;
   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;
endpackage

// File: rtl/parity_rx_if.sv
// parity_rx_if: serial-in strobe bus and recovered-word result bus of the receiver
interface parity_rx_if #(
   parameter int width     = 8,
   parameter int cnt_width = 8
);
   logic                 sin;
   logic                 sin_valid;
   logic                 clr_err;
   logic [width-1:0]     q;
   logic                 q_valid;
   logic                 parity_err;
   logic                 frame_err;
   logic                 busy;
   logic [cnt_width-1:0] err_count;
   modport master (
      output sin, sin_valid, clr_err,
      input  q, q_valid, parity_err, frame_err, busy, err_count
   );
   modport slave (
      input  sin, sin_valid, clr_err,
      output q, q_valid, parity_err, frame_err, busy, err_count
   );
endinterface

// File: rtl/shift_reg_in.sv
// shift_reg_in: right-shift register loading at the MSB so the first bit ends in bit 0
module shift_reg_in #(
   parameter int width = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_en,
   input  logic             i_d,
   output logic [width-1:0] o_q
);
   logic [width-1:0] r_q;
   // shift one bit in per enabled cycle
   always_ff @(posedge clk) begin
      if (reset)
         r_q <= '0;
      else if (i_en)
         r_q <= width > 1 ? {i_d, r_q[width-1:1]} : i_d;
   end
   assign o_q = r_q;
endmodule

// File: rtl/parity_rx.sv
// parity_rx: serial start/data/parity/stop frame receiver with parity and framing checks
module parity_rx
   import parity_pkg::*;
#(
   parameter int width      = 8,
   parameter int odd_parity = 0,
   parameter int cnt_width  = 8
) (
   input  logic       clk,
   input  logic       reset,
   parity_rx_if.slave rx
);
   localparam int bw = width > 1 ? $clog2(width) : 1;
   localparam logic [bw-1:0] last_bit = bw'(width - 1);
   rx_state_t            r_state;
   logic                 r_busy;
   logic [bw-1:0]        r_bit_cnt;
   logic                 r_par_bit;
   logic [width-1:0]     r_q;
   logic                 r_q_valid;
   logic                 r_par_err;
   logic                 r_frm_err;
   logic [cnt_width-1:0] r_err_cnt;
   logic [width-1:0]     w_sr;
   logic                 w_shift;
   logic                 w_stop;
   logic                 w_par_err;
   logic                 w_frm_err;
   logic                 w_err_inc;
   assign w_shift   = rx.sin_valid && r_state == DATA;
   assign w_stop    = rx.sin_valid && r_state == STOP;
   assign w_par_err = ((^w_sr) ^ r_par_bit) != 1'(odd_parity);
   assign w_frm_err = rx.sin != STOP_BIT;
   assign w_err_inc = w_stop && (w_par_err || w_frm_err) && r_err_cnt != '1;
   shift_reg_in #(.width(width)) u_sr (
      .clk   (clk),
      .reset (reset),
      .i_en  (w_shift),
      .i_d   (rx.sin),
      .o_q   (w_sr)
   );
   // frame sequencing; every state move and result update waits for a bit strobe
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_busy    <= 1'b0;
         r_bit_cnt <= '0;
         r_par_bit <= 1'b0;
         r_q       <= '0;
         r_q_valid <= 1'b0;
         r_par_err <= 1'b0;
         r_frm_err <= 1'b0;
      end else begin
         r_q_valid <= 1'b0;
         if (rx.sin_valid) begin
            case (r_state)
               IDLE: if (rx.sin == START_BIT) begin
                  r_state   <= DATA;
                  r_busy    <= 1'b1;
                  r_bit_cnt <= '0;
               end
               DATA: begin
                  r_bit_cnt <= r_bit_cnt == last_bit ? '0 : r_bit_cnt + 1'b1;
                  r_state   <= r_bit_cnt == last_bit ? PARITY : DATA;
               end
               PARITY: begin
                  r_par_bit <= rx.sin;
                  r_state   <= STOP;
               end
               default: begin
                  r_q       <= w_sr;
                  r_q_valid <= 1'b1;
                  r_par_err <= w_par_err;
                  r_frm_err <= w_frm_err;
                  r_state   <= IDLE;
                  r_busy    <= 1'b0;
               end
            endcase
         end
      end
   end
   // saturating count of errored frames; a clear beats a same-cycle increment
   always_ff @(posedge clk) begin
      if (reset || rx.clr_err)
         r_err_cnt <= '0;
      else if (w_err_inc)
         r_err_cnt <= r_err_cnt + 1'b1;
   end
   assign rx.q          = r_q;
   assign rx.q_valid    = r_q_valid;
   assign rx.parity_err = r_par_err;
   assign rx.frame_err  = r_frm_err;
   assign rx.busy       = r_busy;
   assign rx.err_count  = r_err_cnt;
endmodule

// File: tb/tb_parity_rx.sv
// tb_parity_rx: directed frames against even- and odd-parity receivers
module tb_parity_rx;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic a_sin = 1'b1, a_v = 1'b0, a_clr = 1'b0;
   logic o_sin = 1'b1, o_v = 1'b0, o_clr = 1'b0;
   int checks = 0;
   int errors = 0;
   int nvalid = 0;
   logic busy_bad;
   parity_rx_if #(.width(8), .cnt_width(8)) ifa ();
   parity_rx_if #(.width(8), .cnt_width(8)) ifo ();
   assign ifa.sin       = a_sin;
   assign ifa.sin_valid = a_v;
   assign ifa.clr_err   = a_clr;
   assign ifo.sin       = o_sin;
   assign ifo.sin_valid = o_v;
   assign ifo.clr_err   = o_clr;
   parity_rx #(.width(8), .odd_parity(0), .cnt_width(8)) dut (
      .clk(clk), .reset(reset), .rx(ifa.slave));
   parity_rx #(.width(8), .odd_parity(1), .cnt_width(8)) dut_odd (
      .clk(clk), .reset(reset), .rx(ifo.slave));
   always #5 clk = ~clk;
   always @(posedge clk) if (ifa.q_valid) nvalid++;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic send_bit(input bit which, input logic b, input int gap, input bit cb);
      if (which) begin o_sin = b; o_v = 1'b1; end
      else begin a_sin = b; a_v = 1'b1; end
      tick();
      o_v = 1'b0;
      a_v = 1'b0;
      if (cb && !which && !ifa.busy) busy_bad = 1'b1;
      repeat (gap) begin
         tick();
         if (cb && !which && !ifa.busy) busy_bad = 1'b1;
      end
   endtask
   task automatic send_frame(input bit which, input logic [7:0] d, input logic par,
                             input logic stp, input int maxgap, input logic clr);
      busy_bad = 1'b0;
      send_bit(which, 1'b0, $urandom_range(0, maxgap), 1'b1);
      for (int i = 0; i < 8; i++) send_bit(which, d[i], $urandom_range(0, maxgap), 1'b1);
      send_bit(which, par, $urandom_range(0, maxgap), 1'b1);
      a_clr = clr;
      send_bit(which, stp, 0, 1'b0);
      a_clr = 1'b0;
   endtask
   initial begin
      repeat (3) tick();
      chk("rst_q", ifa.q, 0);
      chk("rst_qv", ifa.q_valid, 0);
      chk("rst_perr", ifa.parity_err, 0);
      chk("rst_ferr", ifa.frame_err, 0);
      chk("rst_busy", ifa.busy, 0);
      chk("rst_cnt", ifa.err_count, 0);
      reset = 1'b0;
      tick();
      send_frame(0, 8'hA5, 1'b0, 1'b1, 0, 1'b0);
      chk("a5_q", ifa.q, 8'hA5);
      chk("a5_qv", ifa.q_valid, 1);
      chk("a5_perr", ifa.parity_err, 0);
      chk("a5_ferr", ifa.frame_err, 0);
      chk("a5_cnt", ifa.err_count, 0);
      chk("a5_busy_run", busy_bad, 0);
      tick();
      chk("a5_qv_pulse", ifa.q_valid, 0);
      chk("a5_busy_end", ifa.busy, 0);
      chk("a5_q_hold", ifa.q, 8'hA5);
      send_frame(0, 8'hA5, 1'b1, 1'b1, 0, 1'b0);
      chk("a5p_q", ifa.q, 8'hA5);
      chk("a5p_perr", ifa.parity_err, 1);
      chk("a5p_ferr", ifa.frame_err, 0);
      chk("a5p_cnt", ifa.err_count, 1);
      send_frame(0, 8'h3C, 1'b0, 1'b1, 0, 1'b0);
      chk("3c_q", ifa.q, 8'h3C);
      chk("3c_perr", ifa.parity_err, 0);
      chk("3c_cnt", ifa.err_count, 1);
      send_frame(0, 8'hFF, 1'b0, 1'b0, 0, 1'b0);
      chk("ff_q", ifa.q, 8'hFF);
      chk("ff_ferr", ifa.frame_err, 1);
      chk("ff_perr", ifa.parity_err, 0);
      chk("ff_cnt", ifa.err_count, 2);
      send_bit(0, 1'b1, 2, 1'b0);
      chk("idle_line_busy", ifa.busy, 0);
      send_frame(0, 8'h81, 1'b0, 1'b1, 5, 1'b0);
      chk("81_q", ifa.q, 8'h81);
      chk("81_qv", ifa.q_valid, 1);
      chk("81_perr", ifa.parity_err, 0);
      chk("81_ferr", ifa.frame_err, 0);
      chk("81_cnt", ifa.err_count, 2);
      chk("81_busy_run", busy_bad, 0);
      send_bit(0, 1'b0, 0, 1'b0);
      for (int i = 0; i < 4; i++) send_bit(0, 1'b1, 0, 1'b0);
      chk("mid_busy", ifa.busy, 1);
      begin
         int nv;
         nv = nvalid;
         reset = 1'b1;
         tick();
         reset = 1'b0;
         repeat (3) tick();
         chk("mid_no_qv", nvalid, nv);
      end
      chk("mid_busy_rst", ifa.busy, 0);
      chk("mid_q_rst", ifa.q, 0);
      chk("mid_cnt_rst", ifa.err_count, 0);
      send_frame(0, 8'h0F, 1'b0, 1'b1, 0, 1'b0);
      chk("0f_q", ifa.q, 8'h0F);
      chk("0f_perr", ifa.parity_err, 0);
      chk("0f_cnt", ifa.err_count, 0);
      send_frame(1, 8'h0F, 1'b1, 1'b1, 0, 1'b0);
      chk("odd_q", ifo.q, 8'h0F);
      chk("odd_qv", ifo.q_valid, 1);
      chk("odd_perr_ok", ifo.parity_err, 0);
      send_frame(1, 8'h0F, 1'b0, 1'b1, 0, 1'b0);
      chk("odd_perr_bad", ifo.parity_err, 1);
      chk("odd_cnt", ifo.err_count, 1);
      for (int i = 1; i <= 256; i++) begin
         send_frame(0, 8'h00, 1'b1, 1'b1, 0, 1'b0);
         if (i == 254) chk("sat_254", ifa.err_count, 8'hFE);
         if (i == 255) chk("sat_255", ifa.err_count, 8'hFF);
      end
      chk("sat_256", ifa.err_count, 8'hFF);
      send_frame(0, 8'h00, 1'b1, 1'b1, 0, 1'b1);
      chk("clr_cnt", ifa.err_count, 0);
      chk("clr_perr", ifa.parity_err, 1);
      send_frame(0, 8'h01, 1'b0, 1'b1, 0, 1'b0);
      chk("after_clr_cnt", ifa.err_count, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
